shared_compress_gf4: RTL

- Stage directly downstream of the 2-share GF(2^4) multiplier, which expands to four cross-product shares Q0..Q3; Q1 and Q2 carry the same fresh mask.
- This block registers the four shares first, as a glitch barrier, so no combinational path mixes unregistered cross-products.
- It then compresses them back to two shares, optionally refreshes them with an internal LFSR mask, and registers the result.
- Two-stage valid/ready pipeline feeding the next shared GF(2^4) operation, e.g. the inverter/squarer, in the TI S-box datapath.

---
 rtl/tis_pkg.sv | 26 ++
 rtl/prng_lfsr16.sv | 40 ++++
 rtl/shared_compress_gf4.sv | 101 ++++++++++
 3 files changed

// File: rtl/tis_pkg.sv
// Shared types and constants for the threshold-implementation S-box datapath.
// Holds GF(2^4) share widths and the mask-generator parameters.
package tis_pkg;

    localparam int GF4_W = 4;
    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;

    typedef logic [GF4_W-1:0] gf4_t;

    typedef struct packed {
        gf4_t q3;
        gf4_t q2;
        gf4_t q1;
        gf4_t q0;
    } qshares_t;

    // One Fibonacci step: shift left, feedback from taps 16,14,13,11.
    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] s
    );
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/prng_lfsr16.sv
// 16-bit Fibonacci LFSR mask source.
// A seed load beats a step; a zero seed falls back to the default value.
module prng_lfsr16
    import tis_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = tis_pkg::SEED_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              step_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // Next state: seed load first, then step, else hold.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == '0) ? SEED_DEFAULT : seed_i;
        end else if (step_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    // State register, reset to the default seed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEED_DEFAULT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/shared_compress_gf4.sv
// Registers four GF(2^4) cross-product shares, then compresses them
// to two shares with an optional LFSR refresh, as a 2-stage pipeline.
module shared_compress_gf4
    import tis_pkg::*;
#(
    parameter bit REFRESH = 1'b1,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = tis_pkg::SEED_DEFAULT
) (
    input  logic              ClkxCI,
    input  logic              RstxBI,
    input  logic [LFSR_W-1:0] SeedxDI,
    input  logic              SeedLoadxSI,
    input  logic              InValidxSI,
    output logic              InReadyxSO,
    input  logic [GF4_W-1:0]  QxDI0,
    input  logic [GF4_W-1:0]  QxDI1,
    input  logic [GF4_W-1:0]  QxDI2,
    input  logic [GF4_W-1:0]  QxDI3,
    output logic              OutValidxSO,
    input  logic              OutReadyxSI,
    output logic [GF4_W-1:0]  AxDO0,
    output logic [GF4_W-1:0]  AxDO1
);

    logic     v1_q, v1_d;
    logic     v2_q, v2_d;
    qshares_t s1_q, s1_d;
    gf4_t     a0_q, a0_d;
    gf4_t     a1_q, a1_d;

    logic adv1;
    logic adv2;
    logic step;
    gf4_t mask;

    logic [LFSR_W-1:0] lfsr;
    logic              unused_lfsr;

    assign adv2 = !v2_q || OutReadyxSI;
    assign adv1 = !v1_q || adv2;
    assign step = adv2 && v1_q;

    assign InReadyxSO  = adv1;
    assign OutValidxSO = v2_q;
    assign AxDO0       = a0_q;
    assign AxDO1       = a1_q;

    assign mask        = REFRESH ? lfsr[GF4_W-1:0] : '0;
    assign unused_lfsr = ^lfsr[LFSR_W-1:GF4_W];

    prng_lfsr16 #(
        .SEED_DEFAULT(SEED_DEFAULT)
    ) u_prng (
        .clk_i  (ClkxCI),
        .rst_ni (RstxBI),
        .load_i (SeedLoadxSI),
        .seed_i (SeedxDI),
        .step_i (step),
        .state_o(lfsr)
    );

    // Next state: share capture in stage 1, pairwise compression in stage 2.
    always_comb begin
        v1_d = v1_q;
        s1_d = s1_q;
        v2_d = v2_q;
        a0_d = a0_q;
        a1_d = a1_q;
        if (adv1) begin
            v1_d = InValidxSI;
            if (InValidxSI) begin
                s1_d = '{q3: QxDI3, q2: QxDI2, q1: QxDI1, q0: QxDI0};
            end
        end
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                a0_d = s1_q.q0 ^ s1_q.q1 ^ mask;
                a1_d = s1_q.q2 ^ s1_q.q3 ^ mask;
            end
        end
    end

    // Pipeline registers; the stage-1 bank is the glitch barrier.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            s1_q <= '0;
            a0_q <= '0;
            a1_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            s1_q <= s1_d;
            a0_q <= a0_d;
            a1_q <= a1_d;
        end
    end

endmodule
